// File: rtl/bsr_meta_loader.sv
`default_nettype none
// ============================================================================
// Module   : bsr_meta_loader
// Purpose  : Loads BSR sparse-matrix metadata from a 32-bit stream into the
//            row_ptr and col_idx BRAMs. The stream carries a header word
//            {nnz[15:0], MT[15:0]}, then MT+1 row_ptr words, then
//            ceil(nnz/2) column words holding two 16-bit entries each, with
//            the low half first. Framing errors (code 1) are always detected.
// Options  : BSR_META_CHECK_EN - adds content checks on row_ptr ordering
//            (code 2) and on column entries against KT (code 3).
// Revision : 1.0 - initial release
// ============================================================================
module bsr_meta_loader #(
  parameter int BRAM_ADDR_W = 10,
  parameter int M_W         = 10,
  parameter int K_W         = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [K_W-1:0]         KT,
  input  logic [31:0]            s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   row_ptr_wr_en,
  output logic [BRAM_ADDR_W-1:0] row_ptr_wr_addr,
  output logic [31:0]            row_ptr_wr_data,
  output logic                   col_idx_wr_en,
  output logic [BRAM_ADDR_W-1:0] col_idx_wr_addr,
  output logic [15:0]            col_idx_wr_data,
  output logic [M_W-1:0]         mt_out,
  output logic [31:0]            nnz_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  // Number of entries each BRAM can hold; all size checks compare against it
  // in 33 bits so that 2^BRAM_ADDR_W itself is representable.
  localparam logic [32:0] c_DEPTH = 33'd1 << BRAM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_ROWPTR = 3'd2,
    S_COL_LO = 3'd3,
    S_COL_HI = 3'd4,
    S_DRAIN  = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 r_hi_next;   // where COL_HI goes once the high half is written
  logic [BRAM_ADDR_W-1:0] r_rp_cnt;    // index of the next row_ptr beat
  logic [BRAM_ADDR_W-1:0] r_ci_cnt;    // index of the next col_idx entry
  logic [15:0]            r_hi;        // high half of the last column word

  logic                   w_beat;
  logic [M_W-1:0]         w_hdr_mt;
  logic [15:0]            w_hdr_nnz;
  logic                   w_hdr_bad;
  logic                   w_rp_last;
  logic                   w_nnz_zero;
  logic [32:0]            w_ci_next1;
  logic                   w_odd_final;
  logic                   w_last_word;
  logic                   w_frame_err;
  logic [1:0]             w_chk_code;

  // Handshake and position decodes shared by the error logic and the FSM.
  assign w_beat      = s_tvalid && s_tready;
  assign w_hdr_mt    = s_tdata[M_W-1:0];
  assign w_hdr_nnz   = s_tdata[31:16];
  assign w_hdr_bad   = (w_hdr_mt == '0)
                    || ((33'(w_hdr_mt) + 33'd1) > c_DEPTH)
                    || (33'(w_hdr_nnz) > c_DEPTH)
                    || s_tlast;
  assign w_rp_last   = (33'(r_rp_cnt) == 33'(mt_out));
  assign w_nnz_zero  = (nnz_out == 32'd0);
  assign w_ci_next1  = 33'(r_ci_cnt) + 33'd1;
  // The low half about to be written is the last entry (odd nnz).
  assign w_odd_final = (w_ci_next1 == 33'(nnz_out));
  // The word being accepted is the last column word of the stream.
  assign w_last_word = w_odd_final || ((w_ci_next1 + 33'd1) == 33'(nnz_out));

`ifndef BSR_META_CHECK_EN
  // KT only feeds the content checks, which are not built in this variant.
  logic w_unused_kt;
  assign w_unused_kt = ^KT;
`endif

  // Classify the current cycle: framing error on an accepted beat, plus the
  // optional content error code for the entry being written this cycle.
  always_comb begin
    w_frame_err = 1'b0;
    w_chk_code  = 2'd0;
    case (r_state)
      S_HDR: begin
        if (w_beat) w_frame_err = w_hdr_bad;
      end
      S_ROWPTR: begin
        // tlast belongs on the final row_ptr beat only when no column words follow.
        if (w_beat) w_frame_err = (w_rp_last && w_nnz_zero) ? !s_tlast : s_tlast;
      end
      S_COL_LO: begin
        if (w_beat) w_frame_err = w_last_word ? !s_tlast : s_tlast;
      end
      default: ;
    endcase
`ifdef BSR_META_CHECK_EN
    // row_ptr_wr_data still holds the previous row_ptr value while in ROWPTR.
    case (r_state)
      S_ROWPTR: begin
        if (w_beat) begin
          if (((r_rp_cnt == '0) && (s_tdata != 32'd0))
              || ((r_rp_cnt != '0) && (s_tdata < row_ptr_wr_data))
              || (w_rp_last && (s_tdata != nnz_out)))
            w_chk_code = 2'd2;
        end
      end
      S_COL_LO: begin
        if (w_beat && (32'(s_tdata[15:0]) >= 32'(KT))) w_chk_code = 2'd3;
      end
      S_COL_HI: begin
        if (32'(r_hi) >= 32'(KT)) w_chk_code = 2'd3;
      end
      default: ;
    endcase
`endif
  end

  // Load sequencer: walks the stream, issues registered BRAM writes and
  // records the first error seen during the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_hi_next       <= S_IDLE;
      r_rp_cnt        <= '0;
      r_ci_cnt        <= '0;
      r_hi            <= 16'd0;
      s_tready        <= 1'b0;
      row_ptr_wr_en   <= 1'b0;
      row_ptr_wr_addr <= '0;
      row_ptr_wr_data <= 32'd0;
      col_idx_wr_en   <= 1'b0;
      col_idx_wr_addr <= '0;
      col_idx_wr_data <= 16'd0;
      mt_out          <= '0;
      nnz_out         <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_code        <= 2'd0;
    end else begin
      done          <= 1'b0;
      row_ptr_wr_en <= 1'b0;
      col_idx_wr_en <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        // Abandon the load silently; err keeps its previous value.
        r_state  <= S_IDLE;
        busy     <= 1'b0;
        s_tready <= 1'b0;
      end else begin
        // First error wins; a framing error beats a content error in the same cycle.
        if ((r_state != S_IDLE) && (err_code == 2'd0)) begin
          if (w_frame_err)               err_code <= 2'd1;
          else if (w_chk_code != 2'd0)   err_code <= w_chk_code;
        end
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state  <= S_HDR;
              busy     <= 1'b1;
              err      <= 1'b0;
              err_code <= 2'd0;
              s_tready <= 1'b1;
            end
          end
          S_HDR: begin
            if (w_beat) begin
              mt_out   <= w_hdr_mt;
              nnz_out  <= {16'd0, w_hdr_nnz};
              r_rp_cnt <= '0;
              r_ci_cnt <= '0;
              if (s_tlast) begin
                // The stream has already ended; there is nothing left to drain.
                r_state  <= S_FIN;
                s_tready <= 1'b0;
              end else if (w_hdr_bad) begin
                r_state  <= S_DRAIN;
              end else begin
                r_state  <= S_ROWPTR;
              end
            end
          end
          S_ROWPTR: begin
            if (w_beat) begin
              row_ptr_wr_en   <= 1'b1;
              row_ptr_wr_addr <= r_rp_cnt;
              row_ptr_wr_data <= s_tdata;
              r_rp_cnt        <= r_rp_cnt + BRAM_ADDR_W'(1);
              if (s_tlast && !(w_rp_last && !w_nnz_zero)) begin
                // Either the legitimate end of an empty-matrix load or an early end.
                r_state  <= S_FIN;
                s_tready <= 1'b0;
              end else if (s_tlast) begin
                r_state  <= S_FIN;
                s_tready <= 1'b0;
              end else if (w_rp_last) begin
                r_state  <= w_nnz_zero ? S_DRAIN : S_COL_LO;
              end
            end
          end
          S_COL_LO: begin
            if (w_beat) begin
              col_idx_wr_en   <= 1'b1;
              col_idx_wr_addr <= r_ci_cnt;
              col_idx_wr_data <= s_tdata[15:0];
              r_hi            <= s_tdata[31:16];
              r_ci_cnt        <= r_ci_cnt + BRAM_ADDR_W'(1);
              if (w_odd_final) begin
                // Odd nnz: the high half of the final word is padding.
                r_state  <= s_tlast ? S_FIN : S_DRAIN;
                s_tready <= !s_tlast;
              end else begin
                r_state   <= S_COL_HI;
                s_tready  <= 1'b0;
                r_hi_next <= s_tlast ? S_FIN : (w_last_word ? S_DRAIN : S_COL_LO);
              end
            end
          end
          S_COL_HI: begin
            col_idx_wr_en   <= 1'b1;
            col_idx_wr_addr <= r_ci_cnt;
            col_idx_wr_data <= r_hi;
            r_ci_cnt        <= r_ci_cnt + BRAM_ADDR_W'(1);
            r_state         <= r_hi_next;
            s_tready        <= (r_hi_next != S_FIN);
          end
          S_DRAIN: begin
            if (w_beat && s_tlast) begin
              r_state  <= S_FIN;
              s_tready <= 1'b0;
            end
          end
          S_FIN: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            err     <= (err_code != 2'd0);
            r_state <= S_IDLE;
          end
          default: begin
            r_state  <= S_IDLE;
            s_tready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsr_meta_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsr_meta_loader
// Purpose  : Self-checking bench for bsr_meta_loader. Directed and random
//            metadata loads are compared against a queue-based model that
//            derives the expected BRAM contents and error code directly
//            from the stream description.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsr_meta_loader;

  localparam int AW = 10;
  localparam int MW = 10;
  localparam int KW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] KT = KW'(16);
  logic [31:0]   s_tdata = 32'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          row_ptr_wr_en;
  logic [AW-1:0] row_ptr_wr_addr;
  logic [31:0]   row_ptr_wr_data;
  logic          col_idx_wr_en;
  logic [AW-1:0] col_idx_wr_addr;
  logic [15:0]   col_idx_wr_data;
  logic [MW-1:0] mt_out;
  logic [31:0]   nnz_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  bsr_meta_loader #(.BRAM_ADDR_W(AW), .M_W(MW), .K_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .KT(KT),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .row_ptr_wr_en(row_ptr_wr_en), .row_ptr_wr_addr(row_ptr_wr_addr),
    .row_ptr_wr_data(row_ptr_wr_data), .col_idx_wr_en(col_idx_wr_en),
    .col_idx_wr_addr(col_idx_wr_addr), .col_idx_wr_data(col_idx_wr_data),
    .mt_out(mt_out), .nnz_out(nnz_out), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observed BRAM writes and done pulses.
  int rp_a[$], rp_d[$], ci_a[$], ci_d[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (row_ptr_wr_en) begin rp_a.push_back(int'(row_ptr_wr_addr)); rp_d.push_back(int'(row_ptr_wr_data)); end
      if (col_idx_wr_en) begin ci_a.push_back(int'(col_idx_wr_addr)); ci_d.push_back(int'(col_idx_wr_data)); end
      if (done) done_cnt++;
    end
  end

  // Stream under test and the expected outcome.
  logic [32:0] beats[$];
  int rp_in[$], ci_in[$];
  int exp_rp[$], exp_ci[$];
  int cur_mt, cur_nnz, kt_val;
  int exp_code, exp_mt, exp_nnz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Error code implied by the stream contents alone (framing assumed clean).
  function automatic int model_code();
    int c;
    c = 0;
`ifdef BSR_META_CHECK_EN
    if (rp_in[0] != 0) c = 2;
    for (int i = 1; i < rp_in.size(); i++) if (rp_in[i] < rp_in[i-1]) c = 2;
    if (rp_in[rp_in.size()-1] != cur_nnz) c = 2;
    if (c == 0) foreach (ci_in[j]) if (ci_in[j] >= kt_val) c = 3;
`endif
    return c;
  endfunction

  // Turn (cur_mt, cur_nnz, rp_in, ci_in) into a well-framed stream and expectations.
  task automatic build_good();
    logic [15:0] hi;
    logic [32:0] t;
    beats.delete();
    beats.push_back({1'b0, 16'(cur_nnz), 16'(cur_mt)});
    foreach (rp_in[i]) beats.push_back({1'b0, 32'(rp_in[i])});
    for (int j = 0; j < cur_nnz; j += 2) begin
      hi = (j + 1 < cur_nnz) ? 16'(ci_in[j+1]) : 16'h0000;
      beats.push_back({1'b0, hi, 16'(ci_in[j])});
    end
    t = beats.pop_back();
    t[32] = 1'b1;
    beats.push_back(t);
    exp_rp = rp_in;
    exp_ci = ci_in;
    exp_code = model_code();
    exp_mt = cur_mt;
    exp_nnz = cur_nnz;
    KT = KW'(kt_val);
  endtask

  task automatic drive(input int vmode, input bit noise);
    int idx, cyc;
    bit v, acc;
    logic [32:0] cur;
    idx = 0;
    cyc = 0;
    while (idx < beats.size() && cyc < 400) begin
      @(negedge clk);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cur = beats[idx];
      s_tvalid = v;
      s_tdata = cur[31:0];
      s_tlast = cur[32];
      if (noise) start = 1'($urandom_range(0, 1));
      acc = v && s_tready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    start = 1'b0;
    chk("beats_consumed", idx, beats.size());
  endtask

  task automatic begin_load();
    rp_a.delete(); rp_d.delete(); ci_a.delete(); ci_d.delete();
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_load(input int vmode, input bit noise);
    begin_load();
    drive(vmode, noise);
    wait_done();
  endtask

  task automatic check_load(input string tag);
    chk({tag, ".done"}, done_cnt, 1);
    chk({tag, ".err"}, err, (exp_code != 0));
    chk({tag, ".err_code"}, err_code, exp_code);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".mt_out"}, mt_out, exp_mt);
    chk({tag, ".nnz_out"}, nnz_out, exp_nnz);
    chk({tag, ".rp_count"}, rp_a.size(), exp_rp.size());
    foreach (exp_rp[i]) if (i < rp_a.size()) begin
      chk($sformatf("%s.rp_addr%0d", tag, i), rp_a[i], i);
      chk($sformatf("%s.rp_data%0d", tag, i), rp_d[i], exp_rp[i]);
    end
    chk({tag, ".ci_count"}, ci_a.size(), exp_ci.size());
    foreach (exp_ci[i]) if (i < ci_a.size()) begin
      chk($sformatf("%s.ci_addr%0d", tag, i), ci_a[i], i);
      chk($sformatf("%s.ci_data%0d", tag, i), ci_d[i], exp_ci[i]);
    end
  endtask

  // Framing-error stream: the given beats, no content-based expectations.
  task automatic set_bad(input int mt, input int nnz);
    exp_code = 1;
    exp_mt = mt;
    exp_nnz = nnz;
  endtask

  task automatic load_024();
    cur_mt = 2; cur_nnz = 3; kt_val = 16;
    rp_in = '{0, 2, 3};
    ci_in = '{0, 1, 2};
    build_good();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.s_tready", s_tready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.err_code", err_code, 0);
    chk("rst.rp_wr_en", row_ptr_wr_en, 0);
    chk("rst.ci_wr_en", col_idx_wr_en, 0);
    chk("rst.rp_addr_data", {row_ptr_wr_addr, row_ptr_wr_data[21:0]}, 0);
    chk("rst.ci_addr_data", {col_idx_wr_addr, col_idx_wr_data}, 0);
    chk("rst.mt_nnz", {mt_out, nnz_out[21:0]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.s_tready", s_tready, 0);

    // Basic load, continuous valid
    load_024();
    run_load(0, 1'b0);
    check_load("basic");
    chk("basic.beat_words", beats[4][31:0], 32'h0001_0000);

    // Same load with valid toggling every cycle
    load_024();
    run_load(1, 1'b0);
    check_load("toggle");

    // Empty matrix: row_ptr only
    cur_mt = 1; cur_nnz = 0; kt_val = 16;
    rp_in = '{0, 0};
    ci_in.delete();
    build_good();
    run_load(0, 1'b0);
    check_load("nnz0");

    // Header MT=0 followed by four beats to be drained
    beats = '{{1'b0, 32'h0005_0000}, {1'b0, 32'h1111_1111}, {1'b0, 32'h2222_2222},
              {1'b0, 32'h3333_3333}, {1'b1, 32'h4444_4444}};
    exp_rp.delete(); exp_ci.delete();
    set_bad(0, 5);
    run_load(0, 1'b0);
    check_load("mt0");

    // nnz just above BRAM depth
    beats = '{{1'b0, 32'h0401_0001}, {1'b1, 32'h0000_0000}};
    set_bad(1, 1025);
    run_load(0, 1'b0);
    check_load("nnz_big");

    // MT field truncated to M_W bits gives zero
    beats = '{{1'b0, 32'h0000_0400}, {1'b1, 32'hFFFF_FFFF}};
    set_bad(0, 0);
    run_load(2, 1'b0);
    check_load("mt_trunc");

    // Entry beyond KT
    cur_mt = 1; cur_nnz = 2; kt_val = 4;
    rp_in = '{0, 2};
    ci_in = '{1, 5};
    build_good();
`ifdef BSR_META_CHECK_EN
    chk("kt.model", exp_code, 3);
`else
    chk("kt.model", exp_code, 0);
`endif
    run_load(0, 1'b0);
    check_load("kt");

    // Early tlast inside row_ptr phase
    beats = '{{1'b0, 32'h0003_0002}, {1'b0, 32'd0}, {1'b1, 32'd2}};
    exp_rp = '{0, 2}; exp_ci.delete();
    KT = KW'(16);
    set_bad(2, 3);
    run_load(0, 1'b0);
    check_load("early_tlast");

    // Missing tlast on last row_ptr beat of empty matrix
    beats = '{{1'b0, 32'h0000_0001}, {1'b0, 32'd0}, {1'b0, 32'd0},
              {1'b0, 32'h0000_DEAD}, {1'b1, 32'h0000_BEEF}};
    exp_rp = '{0, 0}; exp_ci.delete();
    set_bad(1, 0);
    run_load(0, 1'b0);
    check_load("miss_tlast_rp");

    // Missing tlast on final (even) column word
    beats = '{{1'b0, 32'h0002_0001}, {1'b0, 32'd0}, {1'b0, 32'd2},
              {1'b0, 32'h0001_0003}, {1'b1, 32'h0000_0007}};
    exp_rp = '{0, 2}; exp_ci = '{3, 1};
    set_bad(1, 2);
    run_load(2, 1'b0);
    check_load("miss_tlast_col");

    // Abort while in COL_HI
    beats = '{{1'b0, 32'h0004_0001}, {1'b0, 32'd0}, {1'b0, 32'd4}};
    KT = KW'(16);
    begin_load();
    drive(0, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'h0002_0001; s_tlast = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("abort.colhi_tready", s_tready, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.s_tready", s_tready, 0);
    repeat (6) @(negedge clk);
    chk("abort.ci_count", ci_a.size(), 1);
    chk("abort.ci_data0", (ci_d.size() > 0) ? ci_d[0] : -1, 1);
    chk("abort.done", done_cnt, 0);
    chk("abort.err", err, 0);
    load_024();
    run_load(0, 1'b0);
    check_load("after_abort");

    // Reset in the middle of a load; stale valid beats must be ignored
    beats = '{{1'b0, 32'h0003_0002}, {1'b0, 32'd0}};
    begin_load();
    drive(0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rp_a.delete(); ci_a.delete(); done_cnt = 0;
    s_tvalid = 1'b1; s_tdata = 32'd2;
    repeat (4) @(negedge clk);
    chk("rstmid.s_tready", s_tready, 0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.writes", rp_a.size() + ci_a.size(), 0);
    s_tvalid = 1'b0;
    load_024();
    run_load(0, 1'b0);
    check_load("after_rst");

    // Random well-framed loads with random valid gaps and spurious start pulses
    for (int it = 0; it < 12; it++) begin
      cur_mt = int'($urandom_range(1, 6));
      cur_nnz = int'($urandom_range(0, 9));
      kt_val = int'($urandom_range(1, 20));
      rp_in.delete();
      rp_in.push_back(0);
      for (int i = 1; i < cur_mt; i++)
        rp_in.push_back(rp_in[i-1] + int'($urandom_range(0, cur_nnz - rp_in[i-1])));
      rp_in.push_back(cur_nnz);
      ci_in.delete();
      for (int j = 0; j < cur_nnz; j++) ci_in.push_back(int'($urandom_range(0, kt_val - 1)));
      if (cur_nnz > 0 && $urandom_range(0, 3) == 0)
        ci_in[$urandom_range(0, cur_nnz - 1)] = kt_val + int'($urandom_range(0, 5));
      build_good();
      run_load(2, 1'b1);
      check_load($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bsr_meta_loader.md
BSR_META_LOADER -- requirements
Module: bsr_meta_loader

Interface
REQ-001 Parameter BRAM_ADDR_W, default 10, address width of row_ptr and col_idx BRAMs.
REQ-002 Parameter M_W, default 10, width of tile-row count MT.
REQ-003 Parameter K_W, default 12, width of K tile count KT.
REQ-004 Ports SHALL be: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low; start in 1 begin load; abort in 1 cancel; KT in K_W column bound; s_tdata in 32 stream word; s_tvalid in 1; s_tlast in 1; s_tready out 1; row_ptr_wr_en out 1; row_ptr_wr_addr out BRAM_ADDR_W; row_ptr_wr_data out 32; col_idx_wr_en out 1; col_idx_wr_addr out BRAM_ADDR_W; col_idx_wr_data out 16; mt_out out M_W latched MT; nnz_out out 32 latched block count; busy out 1; done out 1 pulse; err out 1; err_code out 2.

Function
REQ-005 Beat accepted only when s_tvalid && s_tready on a rising clk edge.
REQ-006 FSM states IDLE, HDR, ROWPTR, COL_LO, COL_HI, DRAIN, FIN.
REQ-007 IDLE: s_tready=0; start -> HDR, busy=1, err=0, err_code=0; start while busy ignored.
REQ-008 HDR: s_tready=1; beat gives MT=s_tdata[15:0] truncated to M_W, nnz=s_tdata[31:16]; latch to mt_out/nnz_out; -> ROWPTR.
REQ-009 Header invalid (MT==0, MT+1 > 2^BRAM_ADDR_W, nnz > 2^BRAM_ADDR_W, or s_tlast set) -> err_code=1, -> DRAIN.
REQ-010 ROWPTR: accepts exactly MT+1 beats; beat i writes row_ptr[i]=s_tdata; wr_en/addr/data registered, asserted the cycle after acceptance, one cycle per beat.
REQ-011 After last row_ptr beat: nnz==0 -> FIN (tlast required on this beat); else -> COL_LO.
REQ-012 Col phase: each word packs two entries, low half first; COL_LO accepts word (s_tready=1), writes low half, -> COL_HI; COL_HI holds s_tready=0, writes stored high half, -> COL_LO; one col_idx write per cycle, address increments 0..nnz-1.
REQ-013 Odd nnz: high half of final word discarded, no write, -> FIN directly from COL_LO.
REQ-014 s_tlast SHALL coincide with the final expected beat; early tlast or missing tlast on final beat -> err_code=1; early tlast -> FIN (stream already ended), missing tlast -> DRAIN.
REQ-015 DRAIN: s_tready=1, no BRAM writes, discard beats through s_tlast inclusive, -> FIN.
REQ-016 FIN: done pulses 1 cycle, busy=0, err=(err_code!=0), err/err_code hold until next start; -> IDLE.
REQ-017 First error recorded wins; later errors do not overwrite err_code.
REQ-018 abort in any non-IDLE state: -> IDLE next cycle, busy=0, s_tready=0, no write issued that cycle, done not pulsed, err unchanged.
REQ-019 Address arithmetic SHALL use BRAM_ADDR_W-bit counters with no wrap (bounds guaranteed by REQ-009).

Reset
REQ-020 On rst_n low: state=IDLE; s_tready, busy, done, err, row_ptr_wr_en, col_idx_wr_en=0; err_code, mt_out, nnz_out, all addr/data outputs=0.
REQ-021 Reset deassertion mid-stream leaves block in IDLE; stale beats not consumed until next start.

Configuration
REQ-022 Macro BSR_META_CHECK_EN defined: row_ptr[0]!=0, row_ptr[i]<row_ptr[i-1], or row_ptr[MT]!=nnz -> err_code=2; col_idx entry >= KT -> err_code=3; writes still issued, load continues, error reported at FIN.
REQ-023 Macro undefined: content checks absent, codes 2/3 never produced; framing checks (code 1) always present.

Verification
REQ-024 MT=2,nnz=3, row_ptr {0,2,3}, col words {0x0001_0000, 0x0000_0002} tlast on last -> 3 row_ptr writes, col writes addr0=0,addr1=1,addr2=2, done, err=0.
REQ-025 Header MT=0 with 4 trailing beats, tlast on 4th -> err_code=1, all beats drained, zero writes, done once.
REQ-026 MT=1,nnz=0, row_ptr {0,0} tlast on 2nd -> 2 row_ptr writes, no col writes, done err=0.
REQ-027 BSR_META_CHECK_EN, KT=4, col entry 5 -> write still issued, done with err_code=3; same stimulus without macro -> err=0.
REQ-028 s_tvalid toggling 1/0 every cycle during col phase -> write sequence identical to REQ-024, no beat lost or duplicated.
REQ-029 abort asserted during COL_HI -> busy=0 and s_tready=0 next cycle, no further writes, no done; subsequent start loads correctly.
